// File: rtl/unidad_ejecucion.sv
// Execution unit: single-cycle ALU ops plus a 32-iteration shift-add multiplier.
// Latency: 1 edge for non-MUL ops, 32 edges after acceptance for MUL.
// Backpressure: a pending result is held until listo_in; listo_out is low while multiplying.
//
// Ports:
//   clk, reset                 - single clock, asynchronous active-high reset
//   dato_a, dato_b, alu_func   - operands and operation code, sampled only on acceptance
//   valido_in / listo_out      - upstream handshake (accept on valido_in && listo_out)
//   resultado, cero, desborde  - registered result, zero flag, signed overflow flag
//   valido_out / listo_in      - downstream handshake (consume on valido_out && listo_in)
module unidad_ejecucion #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [ANCHO-1:0] dato_a,
  input  logic [ANCHO-1:0] dato_b,
  input  logic [3:0]       alu_func,
  input  logic             valido_in,
  output logic             listo_out,
  output logic [ANCHO-1:0] resultado,
  output logic             cero,
  output logic             desborde,
  output logic             valido_out,
  input  logic             listo_in
);

  localparam logic [3:0] F_AND = 4'b0000;
  localparam logic [3:0] F_OR  = 4'b0001;
  localparam logic [3:0] F_ADD = 4'b0010;
  localparam logic [3:0] F_SUB = 4'b0110;
  localparam logic [3:0] F_SLT = 4'b0111;
  localparam logic [3:0] F_NOR = 4'b1100;
  localparam logic [3:0] F_MUL = 4'b1000;

  // Value of the iteration counter on the last shift-add edge (one iteration per operand bit).
  localparam logic [5:0] ULTIMA = 6'(ANCHO - 1);

  typedef enum logic [1:0] {
    REPOSO,
    MULT,
    SALIDA
  } estado_t;

  estado_t          estado, estado_sig;
  logic             acepta;
  logic [ANCHO-1:0] alu_res;
  logic             alu_ovf;
  logic [ANCHO-1:0] suma, resta;

  logic [ANCHO-1:0] mcando;    // multiplicand, shifted left each iteration
  logic [ANCHO-1:0] mdor;      // multiplier, shifted right each iteration
  logic [ANCHO-1:0] acum;
  logic [ANCHO-1:0] acum_sig;
  logic [5:0]       contador;

  // Handshake and next-state logic.
  always_comb begin
    listo_out  = 1'b0;
    estado_sig = estado;
    case (estado)
      REPOSO:  listo_out = 1'b1;
      SALIDA:  listo_out = listo_in;
      default: listo_out = 1'b0;
    endcase

    acepta = valido_in && listo_out;

    if (acepta) begin
      estado_sig = (alu_func == F_MUL) ? MULT : SALIDA;
    end else begin
      case (estado)
        MULT:    if (contador == ULTIMA) estado_sig = SALIDA;
        SALIDA:  if (listo_in) estado_sig = REPOSO;
        default: estado_sig = estado;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) estado <= REPOSO;
    else       estado <= estado_sig;
  end

  // Single-cycle ALU.
  assign suma  = dato_a + dato_b;
  assign resta = dato_a - dato_b;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (alu_func)
      F_AND: alu_res = dato_a & dato_b;
      F_OR:  alu_res = dato_a | dato_b;
      F_ADD: begin
        alu_res = suma;
        alu_ovf = (dato_a[ANCHO-1] == dato_b[ANCHO-1]) && (suma[ANCHO-1] != dato_a[ANCHO-1]);
      end
      F_SUB: begin
        // Subtraction adds ~B, so overflow needs A and B of opposite signs.
        alu_res = resta;
        alu_ovf = (dato_a[ANCHO-1] != dato_b[ANCHO-1]) && (resta[ANCHO-1] != dato_a[ANCHO-1]);
      end
      F_SLT: alu_res = ($signed(dato_a) < $signed(dato_b)) ? {{(ANCHO-1){1'b0}}, 1'b1} : '0;
      F_NOR: alu_res = ~(dato_a | dato_b);
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

  assign acum_sig = mdor[0] ? (acum + mcando) : acum;

  // Datapath and output registers. Only the low ANCHO bits of the product are kept,
  // so the multiplicand may shift out of range without affecting the result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resultado  <= '0;
      cero       <= 1'b0;
      desborde   <= 1'b0;
      valido_out <= 1'b0;
      mcando     <= '0;
      mdor       <= '0;
      acum       <= '0;
      contador   <= '0;
    end else if (acepta) begin
      if (alu_func == F_MUL) begin
        mcando     <= dato_a;
        mdor       <= dato_b;
        acum       <= '0;
        contador   <= '0;
        valido_out <= 1'b0;
      end else begin
        resultado  <= alu_res;
        cero       <= (alu_res == '0);
        desborde   <= alu_ovf;
        valido_out <= 1'b1;
      end
    end else if (estado == MULT) begin
      acum     <= acum_sig;
      mcando   <= mcando << 1;
      mdor     <= mdor >> 1;
      contador <= contador + 6'd1;
      if (contador == ULTIMA) begin
        resultado  <= acum_sig;
        cero       <= (acum_sig == '0);
        desborde   <= 1'b0;
        valido_out <= 1'b1;
      end
    end else if (estado == SALIDA && listo_in) begin
      valido_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_unidad_ejecucion.sv
module tb_unidad_ejecucion;

  logic        clk;
  logic        reset;
  logic [31:0] dato_a, dato_b;
  logic [3:0]  alu_func;
  logic        valido_in;
  logic        listo_out;
  logic [31:0] resultado;
  logic        cero, desborde, valido_out;
  logic        listo_in;

  int checks = 0;
  int errors = 0;

  unidad_ejecucion #(.ANCHO(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .dato_a     (dato_a),
    .dato_b     (dato_b),
    .alu_func   (alu_func),
    .valido_in  (valido_in),
    .listo_out  (listo_out),
    .resultado  (resultado),
    .cero       (cero),
    .desborde   (desborde),
    .valido_out (valido_out),
    .listo_in   (listo_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        c;
    logic        d;
  } vec_t;

  vec_t tabla[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  initial begin
    logic        ok;
    logic [31:0] retenido;

    // f, a, b, expected result, cero, desborde
    tabla[0]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
    tabla[1]  = '{4'b0001, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0, 1'b0, 1'b0};
    tabla[2]  = '{4'b0010, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b1};
    tabla[3]  = '{4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    tabla[4]  = '{4'b0010, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1};
    tabla[5]  = '{4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b0};
    tabla[6]  = '{4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0, 1'b0};
    tabla[7]  = '{4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0};
    tabla[8]  = '{4'b0110, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1'b0, 1'b1};
    tabla[9]  = '{4'b0110, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1};
    tabla[10] = '{4'b1100, 32'h0000FFFF, 32'h00FF0000, 32'hFF000000, 1'b0, 1'b0};
    tabla[11] = '{4'b1111, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    tabla[12] = '{4'b0011, 32'h12345678, 32'h00000001, 32'h00000000, 1'b1, 1'b0};
    tabla[13] = '{4'b0110, 32'h00000003, 32'h0000000A, 32'hFFFFFFF9, 1'b0, 1'b0};

    reset     = 1'b1;
    dato_a    = '0;
    dato_b    = '0;
    alu_func  = '0;
    valido_in = 1'b0;
    listo_in  = 1'b1;

    #2;
    chk("reset resultado", resultado, 32'h0);
    chk("reset valido_out", {31'b0, valido_out}, 32'h0);
    chk("reset cero", {31'b0, cero}, 32'h0);
    chk("reset desborde", {31'b0, desborde}, 32'h0);
    chk("reset listo_out", {31'b0, listo_out}, 32'h1);

    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Back-to-back single-cycle operations with the consumer always ready.
    for (int i = 0; i < 14; i++) begin
      alu_func  = tabla[i].f;
      dato_a    = tabla[i].a;
      dato_b    = tabla[i].b;
      valido_in = 1'b1;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d resultado", i), resultado, tabla[i].r);
      chk($sformatf("vec%0d cero", i), {31'b0, cero}, {31'b0, tabla[i].c});
      chk($sformatf("vec%0d desborde", i), {31'b0, desborde}, {31'b0, tabla[i].d});
      chk($sformatf("vec%0d valido_out", i), {31'b0, valido_out}, 32'h1);
      chk($sformatf("vec%0d listo_out", i), {31'b0, listo_out}, 32'h1);
    end

    valido_in = 1'b0;
    @(posedge clk);
    #1;
    chk("drain valido_out", {31'b0, valido_out}, 32'h0);
    chk("drain resultado held", resultado, 32'hFFFFFFF9);

    // Multiply: 0x00010003 * 7 = 0x00070015, 32 edges after acceptance.
    alu_func  = 4'b1000;
    dato_a    = 32'h00010003;
    dato_b    = 32'h00000007;
    valido_in = 1'b1;
    @(posedge clk);
    #1;
    chk("mul accept valido_out", {31'b0, valido_out}, 32'h0);
    chk("mul accept listo_out", {31'b0, listo_out}, 32'h0);
    // Inputs changing during the multiply must be ignored.
    alu_func = 4'b0000;
    dato_a   = 32'hDEADBEEF;
    dato_b   = 32'h12345678;
    ok = 1'b1;
    for (int k = 1; k < 32; k++) begin
      @(posedge clk);
      #1;
      if (listo_out !== 1'b0 || valido_out !== 1'b0) ok = 1'b0;
    end
    chk("mul busy 31 cycles", {31'b0, ok}, 32'h1);
    valido_in = 1'b0;
    @(posedge clk);
    #1;
    chk("mul resultado", resultado, 32'h00070015);
    chk("mul valido_out", {31'b0, valido_out}, 32'h1);
    chk("mul cero", {31'b0, cero}, 32'h0);
    chk("mul desborde", {31'b0, desborde}, 32'h0);

    // Stall the consumer for 5 cycles; output must hold.
    listo_in = 1'b0;
    retenido = resultado;
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      if (resultado !== retenido || valido_out !== 1'b1 || listo_out !== 1'b0) ok = 1'b0;
    end
    chk("stall hold", {31'b0, ok}, 32'h1);
    listo_in = 1'b1;
    #1;
    chk("release listo_out", {31'b0, listo_out}, 32'h1);
    @(posedge clk);
    #1;
    chk("consumed valido_out", {31'b0, valido_out}, 32'h0);
    @(posedge clk);
    #1;
    chk("single consumption", {31'b0, valido_out}, 32'h0);
    chk("idle resultado held", resultado, 32'h00070015);

    // Reset in the middle of a multiply.
    alu_func  = 4'b1000;
    dato_a    = 32'h00001234;
    dato_b    = 32'h00005678;
    valido_in = 1'b1;
    @(posedge clk);
    valido_in = 1'b0;
    for (int k = 0; k < 10; k++) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async reset resultado", resultado, 32'h0);
    chk("async reset valido_out", {31'b0, valido_out}, 32'h0);
    chk("async reset listo_out", {31'b0, listo_out}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    ok = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (valido_out !== 1'b0 || resultado !== 32'h0) ok = 1'b0;
    end
    chk("discarded mul no result", {31'b0, ok}, 32'h1);

    // Acceptance on the very first edge after reset release.
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset     = 1'b0;
    alu_func  = 4'b0000;
    dato_a    = 32'h0000F0F0;
    dato_b    = 32'h0000FF00;
    valido_in = 1'b1;
    @(posedge clk);
    #1;
    chk("post-reset AND resultado", resultado, 32'h0000F000);
    chk("post-reset AND valido_out", {31'b0, valido_out}, 32'h1);
    valido_in = 1'b0;
    @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/unidad_ejecucion.md
UNIDAD_EJECUCION -- requirements
Module: unidad_ejecucion

Interface
REQ-001 Parameter ANCHO, default 32, operand and result width; all values below assume 32.
REQ-002 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 Port reset, input, 1, asynchronous active-high reset.
REQ-004 Port dato_a, input, ANCHO, operand A (register-bank read port 1 value from decode).
REQ-005 Port dato_b, input, ANCHO, operand B (register-bank read port 2 value, or zero, from decode).
REQ-006 Port alu_func, input, 4, operation code from the ALU-control decoder.
REQ-007 Port valido_in, input, 1, decode presents a valid operation.
REQ-008 Port listo_out, output, 1, unit can accept an operation this cycle.
REQ-009 Port resultado, output, ANCHO, registered result.
REQ-010 Port cero, output, 1, registered flag: resultado == 0.
REQ-011 Port desborde, output, 1, registered signed overflow flag (ADD/SUB only, else 0).
REQ-012 Port valido_out, output, 1, resultado/cero/desborde are valid.
REQ-013 Port listo_in, input, 1, downstream consumes the result this cycle.

Function
REQ-014 Encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT (signed, result 1 or 0), 1100 NOR, 1000 MUL (low 32 bits of unsigned product); any other code yields resultado 0, desborde 0.
REQ-015 FSM states SHALL be REPOSO, MULT, SALIDA.
REQ-016 listo_out SHALL be 1 in REPOSO, equal listo_in in SALIDA, and 0 in MULT.
REQ-017 An operation is accepted on an edge where valido_in && listo_out; no other edge samples dato_a/dato_b/alu_func.
REQ-018 Accepted non-MUL op: result, cero, desborde loaded at the accepting edge; valido_out = 1 next cycle; state -> SALIDA (latency 1).
REQ-019 Accepted MUL: operands latched, 6-bit counter cleared, accumulator cleared, state -> MULT, valido_out -> 0.
REQ-020 MULT: each edge performs one shift-add iteration (add shifted multiplicand if current multiplier LSB is 1); after the 32nd iteration edge resultado/cero loaded, desborde = 0, valido_out = 1, state -> SALIDA (latency 32 edges after acceptance).
REQ-021 SALIDA: outputs held stable while listo_in = 0; on listo_in = 1 with no new acceptance, valido_out -> 0, state -> REPOSO.
REQ-022 SALIDA with listo_in = 1 and valido_in = 1: current result consumed and new op accepted on the same edge (back-to-back, one result per cycle for non-MUL).
REQ-023 ADD/SUB wrap modulo 2^32; desborde = 1 when operands' signs (B inverted for SUB) agree and result sign differs.
REQ-024 valido_in and alu_func changes during MULT SHALL be ignored; the in-progress multiply is not aborted.
REQ-025 resultado SHALL hold its last value when valido_out = 0.

Reset
REQ-026 reset = 1 SHALL immediately force state REPOSO, resultado 0, cero 0, desborde 0, valido_out 0, counter 0, regardless of clk.
REQ-027 Reset during MULT or SALIDA SHALL discard the operation; no result is ever produced for it.
REQ-028 First acceptance is possible on the first rising edge after reset deasserts.

Verification
REQ-029 ADD 0x7FFFFFFF + 0x00000001, listo_in=1 -> next cycle resultado 0x80000000, desborde 1, cero 0, valido_out 1.
REQ-030 SUB 5 - 5 then SLT 0xFFFFFFFF,1 back-to-back -> resultado 0 with cero 1, next cycle resultado 1; listo_out stays 1.
REQ-031 MUL 0x00010003 * 0x00000007 -> listo_out 0 for 32 cycles, then resultado 0x00070015, valido_out 1.
REQ-032 Result pending with listo_in=0 for 5 cycles -> resultado/valido_out stable, listo_out 0; release -> one consumption only.
REQ-033 reset asserted mid-MUL (iteration 10) -> outputs zero asynchronously; after release new AND 0xF0F0,0xFF00 -> 0x0000F000.
REQ-034 alu_func 1111 with operands 0xFFFFFFFF,0x1 -> resultado 0, cero 1, desborde 0.
